// File: rtl/calendar_pkg.sv
// Shared calendar types, month tables and the leap-year rule.
package calendar_pkg;

  typedef logic [5:0]  day_t;
  typedef logic [3:0]  month_t;
  typedef logic [11:0] year_t;
  typedef logic [8:0]  doy_t;

  localparam day_t DAYS_IN_MONTH [1:12] = '{
    6'd31, 6'd28, 6'd31, 6'd30, 6'd31, 6'd30,
    6'd31, 6'd31, 6'd30, 6'd31, 6'd30, 6'd31
  };

  localparam doy_t CUM_DAYS_BEFORE [1:12] = '{
    9'd0,   9'd31,  9'd59,  9'd90,  9'd120, 9'd151,
    9'd181, 9'd212, 9'd243, 9'd273, 9'd304, 9'd334
  };

  function automatic logic is_leap(input year_t y, input bit leap_en);
    logic div4, div100, div400;
    div4   = (y[1:0] == 2'b00);
    div100 = ((y % 12'd100) == 12'd0);
    div400 = ((y % 12'd400) == 12'd0);
    return leap_en && div4 && (!div100 || div400);
  endfunction

  // Returns 0 for out-of-range months; callers reject those separately.
  function automatic doy_t cum_days_before(input month_t m, input logic leap);
    doy_t cum;
    cum = '0;
    if (m >= 4'd1 && m <= 4'd12) begin
      cum = CUM_DAYS_BEFORE[m];
      if (leap && m > 4'd2) cum = cum + 9'd1;
    end
    return cum;
  endfunction

endpackage

// File: rtl/days_in_month_lut.sv
// Combinational month-length lookup; yields 0 for months outside 1..12.
module days_in_month_lut
  import calendar_pkg::*;
(
  input  month_t month,
  input  logic   leap,
  output day_t   days
);

  always_comb begin
    days = '0;
    if (month >= 4'd1 && month <= 4'd12) begin
      days = DAYS_IN_MONTH[month];
      if (month == 4'd2 && leap) days = 6'd29;
    end
  end

endmodule

// File: rtl/calendar_date_counter.sv
// Calendar register: advances one day per tick, supports validated loads,
// and tracks a running day-of-year alongside the date fields.
module calendar_date_counter
  import calendar_pkg::*;
#(
  parameter bit          LEAP_EN    = 1'b0,
  parameter int unsigned RESET_YEAR = 2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dayTick,
  input  logic        load,
  input  logic [5:0]  loadDay,
  input  logic [3:0]  loadMonth,
  input  logic [11:0] loadYear,
  output logic [5:0]  dayOfMonth,
  output logic [3:0]  month,
  output logic [11:0] year,
  output logic [8:0]  dayOfYear,
  output logic        yearWrap,
  output logic        loadErr
);

  day_t   dom_q, dom_d;
  month_t mon_q, mon_d;
  year_t  yr_q,  yr_d;
  doy_t   doy_q, doy_d;
  logic   wrap_q, wrap_d;
  logic   err_q, err_d;

  logic cur_leap, load_leap, load_valid;
  day_t cur_days, load_days;

  assign cur_leap  = is_leap(yr_q, LEAP_EN);
  assign load_leap = is_leap(loadYear, LEAP_EN);

  days_in_month_lut u_cur_lut (
    .month (mon_q),
    .leap  (cur_leap),
    .days  (cur_days)
  );

  days_in_month_lut u_load_lut (
    .month (loadMonth),
    .leap  (load_leap),
    .days  (load_days)
  );

  // load_days is 0 for an illegal month, so the day bound also rejects it.
  assign load_valid = (loadMonth >= 4'd1) && (loadMonth <= 4'd12) &&
                      (loadDay != '0) && (loadDay <= load_days);

  always_comb begin
    dom_d  = dom_q;
    mon_d  = mon_q;
    yr_d   = yr_q;
    doy_d  = doy_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      if (load_valid) begin
        dom_d = loadDay;
        mon_d = loadMonth;
        yr_d  = loadYear;
        doy_d = cum_days_before(loadMonth, load_leap) + {3'b000, loadDay};
      end else begin
        err_d = 1'b1;
      end
    end else if (dayTick) begin
      if (dom_q < cur_days) begin
        dom_d = dom_q + 6'd1;
        doy_d = doy_q + 9'd1;
      end else if (mon_q < 4'd12) begin
        dom_d = 6'd1;
        mon_d = mon_q + 4'd1;
        doy_d = doy_q + 9'd1;
      end else begin
        dom_d  = 6'd1;
        mon_d  = 4'd1;
        doy_d  = 9'd1;
        yr_d   = yr_q + 12'd1;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dom_q  <= 6'd1;
      mon_q  <= 4'd1;
      yr_q   <= year_t'(RESET_YEAR);
      doy_q  <= 9'd1;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dom_q  <= dom_d;
      mon_q  <= mon_d;
      yr_q   <= yr_d;
      doy_q  <= doy_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign dayOfMonth = dom_q;
  assign month      = mon_q;
  assign year       = yr_q;
  assign dayOfYear  = doy_q;
  assign yearWrap   = wrap_q;
  assign loadErr    = err_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench: two counters (leap off / leap on) share one stimulus stream
// and are checked every cycle against a plain-arithmetic calendar model.
module tb_calendar_date_counter;

  typedef struct packed {
    logic [5:0]  dom;
    logic [3:0]  mon;
    logic [11:0] yr;
    logic [8:0]  doy;
    logic        wrap;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dayTick = 1'b0;
  logic        load = 1'b0;
  logic [5:0]  loadDay = '0;
  logic [3:0]  loadMonth = '0;
  logic [11:0] loadYear = '0;

  logic [5:0]  dom0, dom1;
  logic [3:0]  mon0, mon1;
  logic [11:0] yr0, yr1;
  logic [8:0]  doy0, doy1;
  logic        wrap0, wrap1, err0, err1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  int md[2], mm[2], my[2];

  always #5 clk = ~clk;

  calendar_date_counter #(.LEAP_EN(1'b0), .RESET_YEAR(2024)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .dayTick(dayTick), .load(load),
    .loadDay(loadDay), .loadMonth(loadMonth), .loadYear(loadYear),
    .dayOfMonth(dom0), .month(mon0), .year(yr0), .dayOfYear(doy0),
    .yearWrap(wrap0), .loadErr(err0)
  );

  calendar_date_counter #(.LEAP_EN(1'b1), .RESET_YEAR(2024)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .dayTick(dayTick), .load(load),
    .loadDay(loadDay), .loadMonth(loadMonth), .loadYear(loadYear),
    .dayOfMonth(dom1), .month(mon1), .year(yr1), .dayOfYear(doy1),
    .yearWrap(wrap1), .loadErr(err1)
  );

  function automatic bit m_leap(int y, bit en);
    return en && (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0));
  endfunction

  function automatic int m_dim(int m, int y, bit en);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && m_leap(y, en)) return 29;
    return t[m-1];
  endfunction

  function automatic int m_doy(int d, int m, int y, bit en);
    int s = d;
    for (int k = 1; k < m; k++) s += m_dim(k, y, en);
    return s;
  endfunction

  task automatic step(bit r, bit t, bit l, int ld, int lm, int ly);
    exp_t e;
    bit en, wrap, err;
    @(negedge clk);
    rst_n     = !r;
    dayTick   = t;
    load      = l;
    loadDay   = 6'(ld);
    loadMonth = 4'(lm);
    loadYear  = 12'(ly);
    for (int i = 0; i < 2; i++) begin
      en = (i == 1);
      wrap = 1'b0;
      err = 1'b0;
      if (r) begin
        md[i] = 1; mm[i] = 1; my[i] = 2024;
      end else if (l) begin
        if (lm >= 1 && lm <= 12 && ld >= 1 && ld <= m_dim(lm, ly, en)) begin
          md[i] = ld; mm[i] = lm; my[i] = ly;
        end else begin
          err = 1'b1;
        end
      end else if (t) begin
        md[i]++;
        if (md[i] > m_dim(mm[i], my[i], en)) begin
          md[i] = 1;
          mm[i]++;
          if (mm[i] > 12) begin
            mm[i] = 1;
            my[i] = (my[i] + 1) % 4096;
            wrap = 1'b1;
          end
        end
      end
      e.dom  = 6'(md[i]);
      e.mon  = 4'(mm[i]);
      e.yr   = 12'(my[i]);
      e.doy  = 9'(m_doy(md[i], mm[i], my[i], en));
      e.wrap = wrap;
      e.err  = err;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic tick(int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic ld(int d, int m, int y);
    step(1'b0, 1'b0, 1'b1, d, m, y);
  endtask

  always @(posedge clk) begin
    exp_t e, got;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      got = {dom0, mon0, yr0, doy0, wrap0, err0};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL leap0 @%0t: got d=%0d m=%0d y=%0d doy=%0d wrap=%0b err=%0b, need d=%0d m=%0d y=%0d doy=%0d wrap=%0b err=%0b",
                 $time, got.dom, got.mon, got.yr, got.doy, got.wrap, got.err,
                 e.dom, e.mon, e.yr, e.doy, e.wrap, e.err);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      got = {dom1, mon1, yr1, doy1, wrap1, err1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL leap1 @%0t: got d=%0d m=%0d y=%0d doy=%0d wrap=%0b err=%0b, need d=%0d m=%0d y=%0d doy=%0d wrap=%0b err=%0b",
                 $time, got.dom, got.mon, got.yr, got.doy, got.wrap, got.err,
                 e.dom, e.mon, e.yr, e.doy, e.wrap, e.err);
      end
    end
  end

  initial begin
    int ticks_done;
    // Reset state, then a month of ticks into February.
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 5, 5, 5);
    tick(31);
    // Year roll from Dec 31.
    ld(31, 12, 2023);
    tick(2);
    // Leap handling (differs between the two instances).
    ld(28, 2, 2024);
    tick(2);
    ld(28, 2, 1900);
    tick(1);
    ld(29, 2, 2000);
    idle(1);
    ld(28, 2, 2024);
    tick(1);
    ld(29, 2, 2024);
    idle(1);
    // Invalid loads must hold state and pulse loadErr.
    ld(1, 13, 2024);
    ld(1, 0, 2024);
    ld(0, 5, 2024);
    ld(31, 4, 2024);
    ld(40, 1, 2024);
    idle(1);
    // Load wins over a simultaneous tick.
    step(1'b0, 1'b1, 1'b1, 15, 6, 2030);
    idle(1);
    // Year counter wrap.
    ld(31, 12, 4095);
    tick(2);
    // Reset in the middle of a tick stream.
    tick(5);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 0, 0, 0);
    tick(3);
    // Random run: at least 400 day advances, sprinkled loads and rare resets.
    ticks_done = 0;
    while (ticks_done < 400) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 6) begin
        step(1'b0, $urandom_range(0, 1) == 1, 1'b1,
             $urandom_range(0, 33), $urandom_range(0, 14), $urandom_range(0, 4095));
      end else if (sel < 7) begin
        step(1'b1, 1'b1, 1'b0, 0, 0, 0);
      end else if (sel < 75) begin
        step(1'b0, 1'b1, 1'b0, 0, 0, 0);
        ticks_done++;
      end else begin
        step(1'b0, 1'b0, 1'b0, 0, 0, 0);
      end
    end
    ld(30, 12, 1999);
    tick(3);
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: pending q0=%0d q1=%0d, need 0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
